bcd_serial_subtractor: RTL and testbench
========================================

Name: bcd_serial_subtractor

Overview:
- Digit-serial, multi-digit BCD subtractor. Computes |A − B| and a sign flag for two packed-BCD operands.
- Processes one 4-bit digit per clock, LSB digit first, with a borrow chain.
- Inverse arithmetic companion to the combinational BCD adder. Sits in the same ALU datapath and returns a BCD magnitude plus sign to the result mux.
- Start/busy/done handshake.

Parameters:
- DIGITS, 2, number of BCD digits per operand (≥1); operand width is 4*DIGITS.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- a  in  4*DIGITS  minuend, packed BCD, digit 0 = bits [3:0].
- b  in  4*DIGITS  subtrahend, packed BCD.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse; result valid.
- diff  out  4*DIGITS  BCD magnitude |a − b|.
- neg  out  1  1 when a < b.
- err  out  1  invalid-digit flag (see Optional Feature).

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, diff=0, neg=0, err=0; internal borrow, digit index and operand registers cleared.
- States: IDLE → SUB → (FIX) → DONE → IDLE.
- IDLE:
  - start=1 latches a, b into internal registers, clears borrow and index, goes to SUB.
  - Operand inputs are not sampled again until the next accepted start.
- SUB, one digit per cycle, index 0..DIGITS−1:
  - t = a_i − b_i − borrow, signed 5-bit.
  - If t<0: d_i = t+10, borrow=1; else d_i = t, borrow=0.
  - d_i is written into diff digit i.
  - After digit DIGITS−1: if final borrow=0 → DONE with neg=0; else → FIX with borrow cleared and index reset.
- FIX (ten's complement of diff), one digit per cycle:
  - d_i ← 0 − d_i − borrow, using the same correction rule.
  - After the last digit → DONE with neg=1.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- busy: 1 in SUB and FIX, 0 in IDLE and DONE.
- Latency from the start-accept edge to the done pulse:
  - DIGITS+1 cycles for a ≥ b.
  - 2*DIGITS+1 cycles for a < b.
- diff, neg and err hold their values from DONE until the next accepted start.
  - On an accepted start, neg and err clear immediately.
  - diff is overwritten digit-by-digit as SUB progresses.
- start while busy or in DONE: ignored, not queued.
- a == b: diff=0, neg=0; never a negative zero.
- rst_n low mid-operation: immediate return to reset values; no done pulse.
- Arithmetic is strictly digit-wise. No binary subtraction of the full operand followed by correction.

Optional Feature:
- Macro: BCD_SUB_INPUT_CHECK_EN.
- Defined:
  - At start-accept, any nibble of a or b greater than 9 sets an internal flag.
  - err is driven from that flag and is valid from the DONE cycle, held like diff.
  - The computation still runs with the same digit rule; diff is then don't-care.
  - Simulation-only $display message on detection.
- Undefined: err tied to 0; no check logic; invalid digits give an unspecified diff.

Test Plan (DIGITS=2):
- Reset, then a=0x45, b=0x23, start pulse → done 3 cycles after accept; diff=0x22, neg=0, err=0.
- a=0x23, b=0x45 → done 5 cycles after accept; diff=0x22, neg=1.
- a=0x50, b=0x07 (borrow across digits) → diff=0x43, neg=0; a=0x00, b=0x99 → diff=0x99, neg=1; a=0x37, b=0x37 → diff=0x00, neg=0.
- start held high through an operation with different a, b on later cycles → only the first operands are used; one done per accept; busy=1 for exactly 2 or 4 cycles.
- rst_n pulsed low during SUB → all outputs 0 immediately; no done; a new start afterwards completes correctly.
- With BCD_SUB_INPUT_CHECK_EN: a=0xA3, b=0x01 → err=1 at done. Without the macro: err=0.

Source files
------------

// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor: |a - b| plus sign, one digit per clock, LSB first.
// Optional build macro BCD_SUB_INPUT_CHECK_EN adds an invalid-digit (nibble > 9) err flag.
module bcd_serial_subtractor #(
    parameter int DIGITS = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] diff,
    output logic                neg,
    output logic                err,
    output logic [1:0]          dbg_state
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Handshake: start is sampled only in IDLE. busy is high in SUB and FIX.
    // done is high for exactly the one DONE cycle. diff/neg/err are valid
    // while done is high and hold until the next accepted start.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [4*DIGITS-1:0] a_q;
    logic [4*DIGITS-1:0] b_q;
    logic [3:0]      diff_r [DIGITS];
    logic [3:0]      a_dig  [DIGITS];
    logic [3:0]      b_dig  [DIGITS];
    logic [IW-1:0]   idx;
    logic            borrow;
    logic            neg_q;
    logic            last;
    logic [3:0]      op_a;
    logic [3:0]      op_b;
    logic [5:0]      t;
    logic            dig_borrow;
    logic [3:0]      dig_val;

    assign dbg_state = state;
    assign busy      = (state == SUB) || (state == FIX);
    assign done      = (state == DONE);
    assign neg       = neg_q;
    assign last      = (idx == IW'(DIGITS - 1));

    always_comb begin
        for (int i = 0; i < DIGITS; i++) begin
            a_dig[i]       = a_q[4*i +: 4];
            b_dig[i]       = b_q[4*i +: 4];
            diff[4*i +: 4] = diff_r[i];
        end
    end

    // SUB computes a_i - b_i - borrow; FIX reuses the same digit rule as 0 - d_i - borrow.
    always_comb begin
        op_a       = 4'd0;
        op_b       = diff_r[idx];
        if (state == SUB) begin
            op_a = a_dig[idx];
            op_b = b_dig[idx];
        end
        t          = {2'b00, op_a} - {2'b00, op_b} - {5'b00000, borrow};
        dig_borrow = t[5];
        dig_val    = dig_borrow ? (t[3:0] + 4'd10) : t[3:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = SUB;
            SUB: begin
                if (last) state_nx = dig_borrow ? FIX : DONE;
            end
            FIX: if (last) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            idx    <= '0;
            borrow <= 1'b0;
            neg_q  <= 1'b0;
            for (int i = 0; i < DIGITS; i++) diff_r[i] <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        idx    <= '0;
                        borrow <= 1'b0;
                        neg_q  <= 1'b0;
                    end
                end
                SUB, FIX: begin
                    diff_r[idx] <= dig_val;
                    if (last) begin
                        idx    <= '0;
                        borrow <= 1'b0;
                        if (state == FIX) neg_q <= 1'b1;
                    end else begin
                        idx    <= idx + IW'(1);
                        borrow <= dig_borrow;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef BCD_SUB_INPUT_CHECK_EN
    logic bad_in;
    logic err_flag;
    logic err_q;

    always_comb begin
        bad_in = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) bad_in = 1'b1;
        end
    end

    // The flag is captured at accept but only published on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_flag <= 1'b0;
            err_q    <= 1'b0;
        end else if (state == IDLE && start) begin
            err_flag <= bad_in;
            err_q    <= 1'b0;
        end else if (state != DONE && state_nx == DONE) begin
            err_q <= err_flag;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n && state == IDLE && start && bad_in)
            $display("bcd_serial_subtractor: invalid BCD digit in a=%h b=%h", a, b);
    end
`endif

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Self-checking bench for bcd_serial_subtractor (DIGITS=2): vector table, corner sequences, random ops.
module tb_bcd_serial_subtractor;

    localparam int DIGITS = 2;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         neg;
    logic         err;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;
    logic [W:0] exp_q[$];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_diff;
        logic         exp_neg;
    } vec_t;

    vec_t vecs[5];

    bcd_serial_subtractor #(.DIGITS(DIGITS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .diff(diff), .neg(neg), .err(err),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int bcd_val(input logic [W-1:0] x);
        int v = 0;
        for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(x[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r = '0;
        int           n = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(n % 10);
            n = n / 10;
        end
        return r;
    endfunction

    function automatic logic has_bad(input logic [W-1:0] x, input logic [W-1:0] y);
        logic r = 1'b0;
        for (int i = 0; i < DIGITS; i++)
            if (x[4*i +: 4] > 4'd9 || y[4*i +: 4] > 4'd9) r = 1'b1;
        return r;
    endfunction

    function automatic logic exp_err(input logic bad);
`ifdef BCD_SUB_INPUT_CHECK_EN
        return bad;
`else
        return 1'b0 & bad;
`endif
    endfunction

    // One full operation; arith=0 skips diff/neg/latency checks for invalid digits.
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                          input logic [W-1:0] e_diff, input logic e_neg, input logic arith);
        int         cycles;
        int         busy_n;
        int         lat;
        logic [W:0] e;
        logic       bad;
        bad = has_bad(oa, ob);
        lat = e_neg ? 2 * DIGITS + 1 : DIGITS + 1;
        exp_q.push_back({e_neg, e_diff});
        @(negedge clk);
        a = oa; b = ob; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 1;
        busy_n = busy ? 1 : 0;
        while (!done && cycles < 50) begin
            @(negedge clk);
            cycles++;
            if (busy) busy_n++;
        end
        e = exp_q.pop_front();
        if (!done) begin
            check("done_timeout", 32'(done), 32'd1);
            return;
        end
        if (arith) begin
            check("latency", 32'(cycles), 32'(lat));
            check("busy_cycles", 32'(busy_n), 32'(lat - 1));
            check("diff", 32'(diff), 32'(e[W-1:0]));
            check("neg", 32'(neg), 32'(e[W]));
        end
        check("err", 32'(err), 32'(exp_err(bad)));
        @(negedge clk);
        check("done_pulse_width", 32'(done), 32'd0);
        if (arith) check("diff_hold", 32'(diff), 32'(e[W-1:0]));
    endtask

    initial begin
        int         da;
        int         db;
        int         dones;
        int         first_done;
        int         busy_n;
        logic [W-1:0] d1;
        logic [W-1:0] d2;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        vecs[0] = '{a: 8'h45, b: 8'h23, exp_diff: 8'h22, exp_neg: 1'b0};
        vecs[1] = '{a: 8'h23, b: 8'h45, exp_diff: 8'h22, exp_neg: 1'b1};
        vecs[2] = '{a: 8'h50, b: 8'h07, exp_diff: 8'h43, exp_neg: 1'b0};
        vecs[3] = '{a: 8'h00, b: 8'h99, exp_diff: 8'h99, exp_neg: 1'b1};
        vecs[4] = '{a: 8'h37, b: 8'h37, exp_diff: 8'h00, exp_neg: 1'b0};

        // Clock/reset
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_neg", 32'(neg), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++)
            run_op(vecs[i].a, vecs[i].b, vecs[i].exp_diff, vecs[i].exp_neg, 1'b1);

        // start held high; operands change after accept
        @(negedge clk);
        a = 8'h45; b = 8'h23; start = 1'b1;
        dones = 0; first_done = 0; busy_n = 0; d1 = '0; d2 = '0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) begin a = 8'h99; b = 8'h00; end
            if (n == 5) start = 1'b0;
            if (busy) busy_n++;
            if (done) begin
                dones++;
                if (dones == 1) begin first_done = n; d1 = diff; end
                else d2 = diff;
            end
        end
        check("held_done_count", 32'(dones), 32'd2);
        check("held_first_latency", 32'(first_done), 32'(DIGITS + 1));
        check("held_first_diff", 32'(d1), 32'h22);
        check("held_second_diff", 32'(d2), 32'h99);
        check("held_busy_total", 32'(busy_n), 32'(2 * DIGITS));

        // Reset during SUB
        @(negedge clk);
        a = 8'h23; b = 8'h45; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_diff", 32'(diff), 32'd0);
        check("midrst_neg", 32'(neg), 32'd0);
        check("midrst_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("midrst_no_done", 32'(dones), 32'd0);
        run_op(8'h23, 8'h45, 8'h22, 1'b1, 1'b1);

        // Invalid digit
        run_op(8'hA3, 8'h01, 8'h00, 1'b0, 1'b0);
        run_op(8'h45, 8'h23, 8'h22, 1'b0, 1'b1);

        // Random valid operands against the integer model
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < DIGITS; i++) begin
                ra[4*i +: 4] = 4'($urandom_range(0, 9));
                rb[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            da = bcd_val(ra);
            db = bcd_val(rb);
            run_op(ra, rb, to_bcd(da < db ? db - da : da - db), (da < db), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
